// File: rtl/adc_touch_pkg.sv
// adc_touch_pkg: shared types and constants for the touch-screen ADC responder.
// Holds the responder FSM state type, the A2..A0 channel codes, the two result
// widths, and the channel-select helper used when a command byte completes.
package adc_touch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StBusy,
        StData,
        StTail
    } state_e;

    localparam logic [2:0] CH_X  = 3'b101;
    localparam logic [2:0] CH_Y  = 3'b001;
    localparam logic [2:0] CH_Z1 = 3'b011;
    localparam logic [2:0] CH_Z2 = 3'b100;

    localparam int unsigned RES_BITS_12 = 12;
    localparam int unsigned RES_BITS_8  = 8;

    // Maps the A2..A0 field onto one of the stimulus values; unused codes read as zero.
    function automatic logic [11:0] select_channel(input logic [2:0]  ch,
                                                   input logic [11:0] x_val,
                                                   input logic [11:0] y_val,
                                                   input logic [11:0] z1_val,
                                                   input logic [11:0] z2_val);
        logic [11:0] val;
        case (ch)
            CH_X:    val = x_val;
            CH_Y:    val = y_val;
            CH_Z1:   val = z1_val;
            CH_Z2:   val = z2_val;
            default: val = 12'h000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/adc_touch_responder_if.sv
// adc_touch_responder_if: the 4-wire touch ADC serial link.
//   cs       chip select, active high (controller -> ADC)
//   dclk     serial clock (controller -> ADC)
//   din      command bit (controller -> ADC)
//   dout     result bit (ADC -> controller)
//   busy     conversion busy (ADC -> controller)
//   penirq_n pen interrupt, active low (ADC -> controller)
// master = touch controller side, slave = ADC/responder side.
interface adc_touch_responder_if;

    logic cs;
    logic dclk;
    logic din;
    logic dout;
    logic busy;
    logic penirq_n;

    modport master (
        output cs,
        output dclk,
        output din,
        input  dout,
        input  busy,
        input  penirq_n
    );

    modport slave (
        input  cs,
        input  dclk,
        input  din,
        output dout,
        output busy,
        output penirq_n
    );

endinterface

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous input followed by an
// edge detector that compares the synchronized level with its previous value.
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   d_i      asynchronous input
//   level_o  synchronized level
//   rise_o   one-cycle pulse on a synchronized 0->1 transition
//   fall_o   one-cycle pulse on a synchronized 1->0 transition
module sync_edge #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    assign level_o = sync_q[Stages-1];
    assign rise_o  = sync_q[Stages-1] & ~prev_q;
    assign fall_o  = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/adc_touch_responder.sv
// adc_touch_responder: device end of the 4-wire touch-screen ADC serial link.
// Captures the command byte on DCLK rising edges, raises BUSY for one DCLK
// period, then shifts the 12- or 8-bit result out on DCLK falling edges.
// All link inputs are synchronized into clk_i; DCLK is treated purely as data.
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   adc_bus      serial link (slave side): cs/dclk/din in, dout/busy/penirq_n out
//   touch_i      stimulus: pen down
//   x_val_i..z2_val_i  stimulus conversion values
//   cmd_byte_o   last complete command byte
//   cmd_valid_o  one-cycle pulse when cmd_byte_o updates
module adc_touch_responder
    import adc_touch_pkg::*;
#(
    parameter int unsigned SyncStages = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    adc_touch_responder_if.slave        adc_bus,
    input  logic                        touch_i,
    input  logic [11:0]                 x_val_i,
    input  logic [11:0]                 y_val_i,
    input  logic [11:0]                 z1_val_i,
    input  logic [11:0]                 z2_val_i,
    output logic [7:0]                  cmd_byte_o,
    output logic                        cmd_valid_o
);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic cs_level, cs_fall, unused_cs_rise;
    logic dclk_rise, dclk_fall, unused_dclk_level;

    sync_edge #(
        .Stages (SyncStages)
    ) u_cs_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (adc_bus.cs),
        .level_o (cs_level),
        .rise_o  (unused_cs_rise),
        .fall_o  (cs_fall)
    );

    sync_edge #(
        .Stages (SyncStages)
    ) u_dclk_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (adc_bus.dclk),
        .level_o (unused_dclk_level),
        .rise_o  (dclk_rise),
        .fall_o  (dclk_fall)
    );

    // DIN uses the same depth as DCLK so a bit and its clock edge stay aligned.
    logic [SyncStages-1:0] din_sync_q;
    logic                  din_s;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            din_sync_q <= '0;
        end else begin
            din_sync_q <= {din_sync_q[SyncStages-2:0], adc_bus.din};
        end
    end

    assign din_s = din_sync_q[SyncStages-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [6:0]  cmd_sr_q, cmd_sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  nbits_q, nbits_d;
    logic [11:0] res_q, res_d;
    logic        dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        penirq_n_q, penirq_n_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [1:0]  pd_q, pd_d;

    logic [7:0]  cmd_word;
    logic [11:0] sel_val;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cmd_sr_q    <= '0;
            bit_cnt_q   <= '0;
            nbits_q     <= 4'(RES_BITS_12);
            res_q       <= '0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            penirq_n_q  <= 1'b1;
            cmd_byte_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            pd_q        <= 2'b00;
        end else begin
            state_q     <= state_d;
            cmd_sr_q    <= cmd_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            nbits_q     <= nbits_d;
            res_q       <= res_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            penirq_n_q  <= penirq_n_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            pd_q        <= pd_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_sr_d    = cmd_sr_q;
        bit_cnt_d   = bit_cnt_q;
        nbits_d     = nbits_q;
        res_d       = res_q;
        dout_d      = dout_q;
        busy_d      = busy_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        pd_d        = pd_q;
        cmd_word    = {cmd_sr_q, din_s};
        sel_val     = select_channel(cmd_word[6:4], x_val_i, y_val_i, z1_val_i, z2_val_i);

        unique case (state_q)
            StIdle: begin
                dout_d    = 1'b0;
                busy_d    = 1'b0;
                bit_cnt_d = '0;
                if (cs_level) begin
                    state_d = StCmd;
                end
            end

            StCmd: begin
                // Zeros before the start bit are ignored; the start bit is bit 7.
                if (dclk_rise && (bit_cnt_q != 4'd0 || din_s)) begin
                    cmd_sr_d  = cmd_word[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        cmd_byte_d  = cmd_word;
                        cmd_valid_d = 1'b1;
                        pd_d        = cmd_word[1:0];
                        bit_cnt_d   = '0;
                        state_d     = StBusy;
                        // Result is frozen here; later stimulus changes are not seen.
                        if (cmd_word[3]) begin
                            res_d   = {sel_val[11:4], 4'h0};
                            nbits_d = 4'(RES_BITS_8);
                        end else begin
                            res_d   = sel_val;
                            nbits_d = 4'(RES_BITS_12);
                        end
                    end
                end
            end

            StBusy: begin
                // First falling edge raises BUSY, the second drops it and presents the MSB.
                if (dclk_fall) begin
                    if (!busy_q) begin
                        busy_d = 1'b1;
                    end else begin
                        busy_d    = 1'b0;
                        dout_d    = res_q[11];
                        res_d     = {res_q[10:0], 1'b0};
                        bit_cnt_d = 4'd1;
                        state_d   = StData;
                    end
                end
            end

            StData: begin
                if (dclk_fall) begin
                    if (bit_cnt_q == nbits_q) begin
                        dout_d  = 1'b0;
                        state_d = StTail;
                    end else begin
                        dout_d    = res_q[11];
                        res_d     = {res_q[10:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            StTail: begin
                dout_d = 1'b0;
                if (!cs_level) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // CS dropping wins over everything, including a coincident DCLK edge.
        if (cs_fall) begin
            state_d     = StIdle;
            dout_d      = 1'b0;
            busy_d      = 1'b0;
            bit_cnt_d   = '0;
            cmd_valid_d = 1'b0;
            cmd_byte_d  = cmd_byte_q;
            pd_d        = pd_q;
        end

        // PD[0] set means the interrupt is disabled by the last command.
        if (state_d == StIdle && !pd_d[0]) begin
            penirq_n_d = ~touch_i;
        end else begin
            penirq_n_d = 1'b1;
        end
    end

    assign adc_bus.dout     = dout_q;
    assign adc_bus.busy     = busy_q;
    assign adc_bus.penirq_n = penirq_n_q;
    assign cmd_byte_o       = cmd_byte_q;
    assign cmd_valid_o      = cmd_valid_q;

endmodule

// File: tb/tb_adc_touch_responder.sv
// Testbench for adc_touch_responder: acts as the touch controller on the serial
// link and checks the DOUT/BUSY stream against a queue of expected bits.
module tb_adc_touch_responder;

    localparam int Half = 6;  // DCLK half period in CLK cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        touch = 1'b1;
    logic [11:0] x_val = 12'h000;
    logic [11:0] y_val = 12'h000;
    logic [11:0] z1_val = 12'h000;
    logic [11:0] z2_val = 12'h000;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;

    adc_touch_responder_if bus ();

    adc_touch_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .adc_bus     (bus),
        .touch_i     (touch),
        .x_val_i     (x_val),
        .y_val_i     (y_val),
        .z1_val_i    (z1_val),
        .z2_val_i    (z2_val),
        .cmd_byte_o  (cmd_byte),
        .cmd_valid_o (cmd_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int n_valid = 0;
    int exp_valid = 0;

    logic exp_dout_q[$];
    logic exp_busy_q[$];

    always @(negedge clk) begin
        if (cmd_valid) n_valid++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [11:0] model_val(input logic [2:0] ch);
        case (ch)
            3'b101:  return x_val;
            3'b001:  return y_val;
            3'b011:  return z1_val;
            3'b100:  return z2_val;
            default: return 12'h000;
        endcase
    endfunction

    // kind: 0 = full frame, 1 = drop CS after stop_after rises, 2 = reset after stop_after rises
    task automatic do_frame(input logic [7:0] cmd, input int lead, input int stop_after,
                            input int kind);
        logic [11:0] word;
        int          n;
        int          total;
        logic        ed;
        logic        eb;
        word = model_val(cmd[6:4]);
        if (cmd[3]) begin
            word = {word[11:4], 4'h0};
            n = 8;
        end else begin
            n = 12;
        end
        total = (kind == 0) ? 24 : stop_after;
        if (total >= 8) exp_valid++;
        bus.cs = 1'b1;
        wait_clks(2 * Half);
        for (int k = 0; k < lead + total; k++) begin
            int j;
            j = k - lead;
            @(negedge clk);
            bus.dclk = 1'b0;
            bus.din  = (j >= 0 && j < 8) ? cmd[7 - j] : 1'b0;
            exp_dout_q.push_back((j >= 9 && j < 9 + n) ? word[20 - j] : 1'b0);
            exp_busy_q.push_back(j == 8);
            wait_clks(Half);
            ed = exp_dout_q.pop_front();
            eb = exp_busy_q.pop_front();
            n_tests++;
            if (bus.dout !== ed) begin
                n_fail++;
                $display("FAIL dout cmd=%h rise=%0d: got %b expected %b", cmd, j + 1, bus.dout, ed);
            end
            n_tests++;
            if (bus.busy !== eb) begin
                n_fail++;
                $display("FAIL busy cmd=%h rise=%0d: got %b expected %b", cmd, j + 1, bus.busy, eb);
            end
            n_tests++;
            if (bus.penirq_n !== 1'b1) begin
                n_fail++;
                $display("FAIL penirq_in_frame cmd=%h rise=%0d: got %b expected 1", cmd, j + 1,
                         bus.penirq_n);
            end
            bus.dclk = 1'b1;
            wait_clks(Half);
            // Capture is long past; scrambling must not disturb this transfer.
            if (j == 7) begin
                x_val  = 12'($urandom);
                y_val  = 12'($urandom);
                z1_val = 12'($urandom);
                z2_val = 12'($urandom);
            end
        end
        if (kind == 0) begin
            @(negedge clk);
            bus.dclk = 1'b0;
            wait_clks(Half);
            bus.cs = 1'b0;
            wait_clks(Half);
        end else if (kind == 1) begin
            @(negedge clk);
            bus.cs = 1'b0;
            wait_clks(4);
            n_tests++;
            if (bus.dout !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_outputs: got dout=%b busy=%b expected 0 0", bus.dout, bus.busy);
            end
            bus.dclk = 1'b0;
            wait_clks(Half);
        end else begin
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            n_tests++;
            if (bus.dout !== 1'b0 || bus.busy !== 1'b0 || bus.penirq_n !== 1'b1 ||
                cmd_byte !== 8'h00 || cmd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_frame: got dout=%b busy=%b penirq_n=%b cmd=%h valid=%b expected 0 0 1 00 0",
                         bus.dout, bus.busy, bus.penirq_n, cmd_byte, cmd_valid);
            end
            rst_n    = 1'b1;
            bus.dclk = 1'b0;
            bus.cs   = 1'b0;
            wait_clks(Half);
        end
        if (kind != 2) begin
            n_tests++;
            if (cmd_byte !== cmd) begin
                n_fail++;
                $display("FAIL cmd_byte: got %h expected %h", cmd_byte, cmd);
            end
        end
        n_tests++;
        if (n_valid != exp_valid) begin
            n_fail++;
            $display("FAIL cmd_valid_count after cmd=%h: got %0d expected %0d", cmd, n_valid,
                     exp_valid);
        end
    endtask

    task automatic test_reset();
        wait_clks(4);
        n_tests++;
        if (bus.dout !== 1'b0 || bus.busy !== 1'b0 || bus.penirq_n !== 1'b1 ||
            cmd_byte !== 8'h00 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got dout=%b busy=%b penirq_n=%b cmd=%h valid=%b expected 0 0 1 00 0",
                     bus.dout, bus.busy, bus.penirq_n, cmd_byte, cmd_valid);
        end
        rst_n = 1'b1;
        touch = 1'b0;
        wait_clks(4);
    endtask

    task automatic test_x_read();
        x_val = 12'hA5C;
        do_frame(8'hD0, 0, 0, 0);
    endtask

    task automatic test_y_8bit();
        y_val = 12'h3F1;
        do_frame(8'h98, 0, 0, 0);
    endtask

    task automatic test_leading_zeros();
        y_val = 12'h6B2;
        do_frame(8'h90, 3, 0, 0);
    endtask

    task automatic test_channels();
        logic [7:0] cmds [3];
        cmds[0] = 8'hB0;  // Z1, 12-bit
        cmds[1] = 8'hC8;  // Z2, 8-bit
        cmds[2] = 8'hE0;  // unmapped code
        for (int i = 0; i < 3; i++) begin
            x_val  = 12'h111;
            y_val  = 12'h222;
            z1_val = 12'h9C3;
            z2_val = 12'h5E7;
            do_frame(cmds[i], 0, 0, 0);
        end
    endtask

    task automatic test_pen_irq();
        touch = 1'b0;
        wait_clks(3);
        n_tests++;
        if (bus.penirq_n !== 1'b1) begin
            n_fail++;
            $display("FAIL penirq_untouched: got %b expected 1", bus.penirq_n);
        end
        touch = 1'b1;
        wait_clks(2);
        n_tests++;
        if (bus.penirq_n !== 1'b0) begin
            n_fail++;
            $display("FAIL penirq_touch: got %b expected 0", bus.penirq_n);
        end
        x_val = 12'h0F0;
        do_frame(8'hD1, 0, 0, 0);
        wait_clks(3);
        n_tests++;
        if (bus.penirq_n !== 1'b1) begin
            n_fail++;
            $display("FAIL penirq_pd01: got %b expected 1", bus.penirq_n);
        end
        x_val = 12'h801;
        do_frame(8'hD0, 0, 0, 0);
        wait_clks(3);
        n_tests++;
        if (bus.penirq_n !== 1'b0) begin
            n_fail++;
            $display("FAIL penirq_pd00: got %b expected 0", bus.penirq_n);
        end
        touch = 1'b0;
        wait_clks(2);
    endtask

    task automatic test_abort();
        x_val = 12'hA5C;
        do_frame(8'hD0, 0, 14, 1);
        x_val = 12'h3C7;
        do_frame(8'hD0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        x_val = 12'hFFF;
        do_frame(8'hD3, 0, 14, 2);
        touch = 1'b1;
        wait_clks(8);
        n_tests++;
        if (bus.penirq_n !== 1'b0 || cmd_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset_state: got penirq_n=%b cmd=%h expected 0 00", bus.penirq_n,
                     cmd_byte);
        end
        touch = 1'b0;
        wait_clks(2);
    endtask

    task automatic test_back_to_back();
        x_val = 12'h5A5;
        do_frame(8'hD0, 0, 0, 0);
        y_val = 12'hC3C;
        do_frame(8'h90, 0, 0, 0);
    endtask

    initial begin
        bus.cs   = 1'b0;
        bus.dclk = 1'b0;
        bus.din  = 1'b0;
        test_reset();
        test_x_read();
        test_y_8bit();
        test_leading_zeros();
        test_channels();
        test_pen_irq();
        test_abort();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
